// File: rtl/game_pkg.sv
// Shared types and constants for the game flow sequencer.
// Optional pause support is built in when GAME_PAUSE_EN is defined.
package game_pkg;

  typedef enum logic [2:0] {
    ST_START     = 3'd0,
    ST_RESPAWN   = 3'd1,
    ST_PLAY      = 3'd2,
    ST_DYING     = 3'd3,
    ST_DEAD_WAIT = 3'd4,
    ST_PAUSE     = 3'd5
  } game_state_t;

  typedef logic [1:0] save_id_t;

  localparam int NUM_SAVES = 3;
  localparam int FCNT_W    = 8;

  // Save points only move forward; id 0 and ids beyond the last save are ignored.
  function automatic save_id_t save_advance(save_id_t cur, save_id_t id);
    if ((id > cur) && (id <= save_id_t'(NUM_SAVES)))
      return id;
    return cur;
  endfunction

endpackage

// File: rtl/key_edge.sv
// Registered rising-edge detector; history resets high so a key held
// through reset release does not produce an edge.
module key_edge (
  input  logic Clk,
  input  logic Reset_n,
  input  logic key,
  output logic rise
);

  logic key_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) key_q <= 1'b1;
    else          key_q <= key;
  end

  assign rise = key & ~key_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Frame-level game sequencer driving the color mapper mode inputs.
// Define GAME_PAUSE_EN to add the PAUSE state controlled by key_pause.
// Handshake: there is no valid/ready pairing here; every input is a level or
// one-cycle pulse sampled on each rising Clk edge, every output is registered.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int DEATH_FRAMES = 60,
  parameter int DCNT_W       = 8
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_tick,
  input  logic              key_start,
  input  logic              key_pause,
  input  logic              kid_hit,
  input  logic              killer_trig,
  input  logic              save_touch,
  input  logic [1:0]        save_id,
  output logic              is_startpage,
  output logic              game_run,
  output logic              is_visiable,
  output logic [1:0]        save,
  output logic              respawn,
  output logic [DCNT_W-1:0] death_cnt,
  output logic [2:0]        dbg_state
);

  localparam logic [FCNT_W-1:0] FRAMES_LAST = FCNT_W'(DEATH_FRAMES);

  game_state_t       state, state_n;
  save_id_t          save_n;
  logic              vis_n;
  logic [DCNT_W-1:0] dcnt_n;
  logic [FCNT_W-1:0] frame_cnt, fcnt_n, fcnt_inc;
  logic              start_rise;

  key_edge u_start_edge (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .key     (key_start),
    .rise    (start_rise)
  );

`ifdef GAME_PAUSE_EN
  logic pause_rise;

  key_edge u_pause_edge (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .key     (key_pause),
    .rise    (pause_rise)
  );
`else
  logic unused_key_pause;
  assign unused_key_pause = key_pause;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ST_START;
      save        <= '0;
      is_visiable <= 1'b0;
      death_cnt   <= '0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_n;
      save        <= save_n;
      is_visiable <= vis_n;
      death_cnt   <= dcnt_n;
      frame_cnt   <= fcnt_n;
    end
  end

  assign fcnt_inc = frame_cnt + 1'b1;

  always_comb begin
    state_n = state;
    save_n  = save;
    vis_n   = is_visiable;
    dcnt_n  = death_cnt;
    fcnt_n  = frame_cnt;
    case (state)
      ST_START: begin
        if (start_rise) begin
          state_n = ST_RESPAWN;
          save_n  = '0;
          vis_n   = 1'b0;
        end
      end
      ST_RESPAWN: begin
        vis_n   = 1'b0;
        state_n = ST_PLAY;
      end
      ST_PLAY: begin
        // Trigger zone reveals killers even on the cycle the kid dies.
        if (killer_trig) vis_n = 1'b1;
        if (kid_hit) begin
          state_n = ST_DYING;
          fcnt_n  = '0;
          if (death_cnt != '1) dcnt_n = death_cnt + 1'b1;
        end else begin
          if (save_touch) save_n = save_advance(save, save_id);
`ifdef GAME_PAUSE_EN
          if (pause_rise) state_n = ST_PAUSE;
`endif
        end
      end
      ST_DYING: begin
        if (frame_tick) begin
          fcnt_n = fcnt_inc;
          if (fcnt_inc == FRAMES_LAST) state_n = ST_DEAD_WAIT;
        end
      end
      ST_DEAD_WAIT: begin
        if (start_rise) begin
          state_n = ST_RESPAWN;
          vis_n   = 1'b0;
        end
      end
`ifdef GAME_PAUSE_EN
      ST_PAUSE: begin
        if (pause_rise) state_n = ST_PLAY;
      end
`endif
      default: state_n = ST_START;
    endcase
  end

  assign is_startpage = (state == ST_START);
  assign game_run     = (state == ST_PLAY);
  assign respawn      = (state == ST_RESPAWN);
  assign dbg_state    = state;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with DEATH_FRAMES=4, DCNT_W=8.
// Define GAME_PAUSE_EN on both bench and RTL to cover the pause path.
module tb_game_flow_ctrl;
  import game_pkg::*;

  localparam int DF = 4;
  localparam int DW = 8;
  localparam int W  = 3 + 1 + 1 + 1 + 2 + 1 + DW;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          frame_tick, key_start, key_pause, kid_hit, killer_trig, save_touch;
  logic [1:0]    save_id;
  logic          is_startpage, game_run, is_visiable, respawn;
  logic [1:0]    save;
  logic [DW-1:0] death_cnt;
  logic [2:0]    dbg_state;

  logic [W-1:0]  exp_q[$];
  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] exp_dc;

  // clock / reset
  always #5 Clk = ~Clk;

  game_flow_ctrl #(.DEATH_FRAMES(DF), .DCNT_W(DW)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_tick   (frame_tick),
    .key_start    (key_start),
    .key_pause    (key_pause),
    .kid_hit      (kid_hit),
    .killer_trig  (killer_trig),
    .save_touch   (save_touch),
    .save_id      (save_id),
    .is_startpage (is_startpage),
    .game_run     (game_run),
    .is_visiable  (is_visiable),
    .save         (save),
    .respawn      (respawn),
    .death_cnt    (death_cnt),
    .dbg_state    (dbg_state)
  );

  // Expected output vector: Moore flags follow from the state alone.
  function automatic logic [W-1:0] pk(game_state_t s, logic [1:0] sv, logic vis, logic [DW-1:0] dc);
    logic [2:0] sb;
    sb = s;
    return {sb, (s == ST_START), (s == ST_PLAY), vis, sv, (s == ST_RESPAWN), dc};
  endfunction

  // driver tasks
  task automatic drive(input logic tick, input logic ks, input logic kp, input logic hit,
                       input logic trig, input logic st, input logic [1:0] sid);
    frame_tick  = tick;
    key_start   = ks;
    key_pause   = kp;
    kid_hit     = hit;
    killer_trig = trig;
    save_touch  = st;
    save_id     = sid;
  endtask

  // scoreboard
  task automatic check(input string tag);
    logic [W-1:0] e, obs;
    e   = exp_q.pop_front();
    obs = {dbg_state, is_startpage, game_run, is_visiable, save, respawn, death_cnt};
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic now(input string tag, input logic [W-1:0] e);
    exp_q.push_back(e);
    check(tag);
  endtask

  task automatic step(input string tag, input logic [W-1:0] e);
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    check(tag);
  endtask

  // One full death/respawn round from PLAY back to PLAY, save held at sv.
  task automatic die_round(input logic [1:0] sv);
    drive(0, 0, 0, 1, 0, 0, 2'd0);
    exp_dc = (exp_dc == '1) ? exp_dc : exp_dc + 1'b1;
    step("die_hit", pk(ST_DYING, sv, 1'b0, exp_dc));
    drive(1, 0, 0, 0, 0, 0, 2'd0);
    for (int k = 1; k < DF; k++) step("die_cnt", pk(ST_DYING, sv, 1'b0, exp_dc));
    step("die_wait", pk(ST_DEAD_WAIT, sv, 1'b0, exp_dc));
    drive(0, 1, 0, 0, 0, 0, 2'd0);
    step("die_rsp", pk(ST_RESPAWN, sv, 1'b0, exp_dc));
    drive(0, 0, 0, 0, 0, 0, 2'd0);
    step("die_play", pk(ST_PLAY, sv, 1'b0, exp_dc));
  endtask

  initial begin
    exp_dc  = '0;
    Reset_n = 1'b0;
    drive(0, 1, 0, 0, 0, 0, 2'd0);
    #2;
    now("reset_vals", pk(ST_START, 2'd0, 1'b0, 8'd0));
    @(negedge Clk);
    Reset_n = 1'b1;
    step("held_start", pk(ST_START, 2'd0, 1'b0, 8'd0));
    step("held_start2", pk(ST_START, 2'd0, 1'b0, 8'd0));
    drive(0, 0, 0, 0, 0, 0, 2'd0);
    step("start_rel", pk(ST_START, 2'd0, 1'b0, 8'd0));
    drive(0, 1, 0, 0, 0, 0, 2'd0);
    step("first_rsp", pk(ST_RESPAWN, 2'd0, 1'b0, 8'd0));
    drive(0, 0, 0, 0, 0, 0, 2'd0);
    step("first_play", pk(ST_PLAY, 2'd0, 1'b0, 8'd0));

    // save points move forward only; id 0 ignored
    drive(0, 0, 0, 0, 0, 1, 2'd0);
    step("save_id0", pk(ST_PLAY, 2'd0, 1'b0, 8'd0));
    drive(0, 0, 0, 0, 0, 1, 2'd2);
    step("save_2", pk(ST_PLAY, 2'd2, 1'b0, 8'd0));
    drive(0, 0, 0, 0, 0, 1, 2'd1);
    step("save_back", pk(ST_PLAY, 2'd2, 1'b0, 8'd0));
    drive(0, 0, 0, 0, 0, 0, 2'd3);
    step("save_notouch", pk(ST_PLAY, 2'd2, 1'b0, 8'd0));

    // hit beats save; trigger still shows killers; coincident tick not counted
    drive(1, 0, 0, 1, 1, 1, 2'd3);
    exp_dc = 8'd1;
    step("hit_combo", pk(ST_DYING, 2'd2, 1'b1, exp_dc));

    // key_start edges ignored while dying; 4th tick reaches DEAD_WAIT
    drive(1, 1, 0, 0, 0, 0, 2'd0);
    step("dying_t1", pk(ST_DYING, 2'd2, 1'b1, exp_dc));
    drive(0, 0, 0, 0, 0, 0, 2'd0);
    step("dying_idle", pk(ST_DYING, 2'd2, 1'b1, exp_dc));
    drive(1, 1, 0, 0, 0, 0, 2'd0);
    step("dying_t2", pk(ST_DYING, 2'd2, 1'b1, exp_dc));
    drive(1, 0, 0, 0, 0, 0, 2'd0);
    step("dying_t3", pk(ST_DYING, 2'd2, 1'b1, exp_dc));
    drive(0, 0, 0, 0, 0, 0, 2'd0);
    step("dying_idle2", pk(ST_DYING, 2'd2, 1'b1, exp_dc));
    drive(1, 0, 0, 0, 0, 0, 2'd0);
    step("dying_t4", pk(ST_DEAD_WAIT, 2'd2, 1'b1, exp_dc));
    drive(0, 0, 0, 0, 0, 0, 2'd0);
    step("dead_wait", pk(ST_DEAD_WAIT, 2'd2, 1'b1, exp_dc));
    drive(0, 1, 0, 0, 0, 0, 2'd0);
    step("restart_rsp", pk(ST_RESPAWN, 2'd2, 1'b0, exp_dc));
    drive(0, 0, 0, 0, 0, 0, 2'd0);
    step("restart_play", pk(ST_PLAY, 2'd2, 1'b0, exp_dc));

    // saturation: 256 deaths in total
    for (int d = 2; d <= 256; d++) die_round(2'd2);
    now("dcnt_sat", pk(ST_PLAY, 2'd2, 1'b0, 8'd255));

    // killer trigger alone, then hold
    drive(0, 0, 0, 0, 1, 0, 2'd0);
    step("trig_on", pk(ST_PLAY, 2'd2, 1'b1, exp_dc));
    drive(0, 0, 0, 0, 0, 0, 2'd0);
    step("trig_hold", pk(ST_PLAY, 2'd2, 1'b1, exp_dc));
`ifndef GAME_PAUSE_EN
    drive(0, 0, 1, 0, 0, 0, 2'd0);
    step("pause_ignored", pk(ST_PLAY, 2'd2, 1'b1, exp_dc));
`endif
    drive(0, 0, 0, 1, 0, 0, 2'd0);
    step("hit_sat", pk(ST_DYING, 2'd2, 1'b1, 8'd255));
    drive(1, 0, 0, 0, 0, 0, 2'd0);
    step("dying_mid", pk(ST_DYING, 2'd2, 1'b1, 8'd255));

    // asynchronous reset mid-DYING
    Reset_n = 1'b0;
    #1;
    exp_dc = '0;
    now("async_rst", pk(ST_START, 2'd0, 1'b0, 8'd0));
    step("rst_hold", pk(ST_START, 2'd0, 1'b0, 8'd0));
    @(negedge Clk);
    Reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 2'd0);
    step("rst_release", pk(ST_START, 2'd0, 1'b0, 8'd0));

`ifdef GAME_PAUSE_EN
    drive(0, 1, 0, 0, 0, 0, 2'd0);
    step("p_rsp", pk(ST_RESPAWN, 2'd0, 1'b0, 8'd0));
    drive(0, 0, 0, 0, 0, 0, 2'd0);
    step("p_play", pk(ST_PLAY, 2'd0, 1'b0, 8'd0));
    drive(0, 0, 1, 0, 0, 0, 2'd0);
    step("p_pause", pk(ST_PAUSE, 2'd0, 1'b0, 8'd0));
    drive(0, 0, 0, 1, 1, 1, 2'd3);
    step("p_ignore", pk(ST_PAUSE, 2'd0, 1'b0, 8'd0));
    drive(0, 0, 1, 0, 0, 0, 2'd0);
    step("p_resume", pk(ST_PLAY, 2'd0, 1'b0, 8'd0));
    drive(0, 0, 0, 0, 0, 0, 2'd0);
    step("p_run", pk(ST_PLAY, 2'd0, 1'b0, 8'd0));
    drive(0, 0, 1, 1, 0, 0, 2'd0);
    step("p_hit_wins", pk(ST_DYING, 2'd0, 1'b0, 8'd1));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Frame-level game sequencer that drives the pixel color mapper's mode inputs: start-page enable, killer visibility, save-point state and kid respawn. It sits between the input/collision logic and the color mapper. It advances on per-frame pulses and key edges, so the per-pixel datapath never carries game state.

## Interface

Parameters:
- DEATH_FRAMES, 60: frames spent in DYING before a restart is accepted (1..255).
- DCNT_W, 8: width of the death counter.

Ports (clock and reset first):
- Clk  in  1  system clock.
- Reset_n  in  1  reset; asynchronous assert, active-low.
- frame_tick  in  1  one-cycle pulse per frame (vsync rise).
- key_start  in  1  start/restart key level, already synchronous to Clk.
- key_pause  in  1  pause key level (used only with GAME_PAUSE_EN).
- kid_hit  in  1  kid/killer or kid/hazard collision, level, valid each cycle.
- killer_trig  in  1  kid entered a killer trigger zone, level.
- save_touch  in  1  kid is shooting a save point.
- save_id  in  2  id of the touched save point (1..3; 0 is ignored).
- is_startpage  out  1  start page displayed.
- game_run  out  1  kid and killers may move this frame.
- is_visiable  out  1  killer sprites shown.
- save  out  2  highest save point activated (0 = none).
- respawn  out  1  one-cycle pulse: move kid to save point `save`.
- death_cnt  out  DCNT_W  deaths since reset, saturating.

## Operation

- States: START, RESPAWN, PLAY, DYING, DEAD_WAIT, plus PAUSE with GAME_PAUSE_EN.
- Outputs are Moore-decoded from registers:
  - is_startpage=1 only in START.
  - game_run=1 only in PLAY.
  - respawn=1 only in RESPAWN.
- Key edges: rising edge = key & ~key_q. key_q resets to 1, so a key held through reset release does not trigger.
- START: a key_start edge → RESPAWN. save is cleared to 0 and is_visiable to 0.
- RESPAWN: lasts exactly 1 cycle. is_visiable is cleared. Next state is PLAY.
- PLAY, evaluated each cycle:
  - kid_hit → DYING. death_cnt increments by 1 and saturates at all-ones.
  - Otherwise, if save_touch and save_id > save, then save <= save_id. Save points only move forward; save_id 0 is ignored.
  - If killer_trig is high, is_visiable <= 1. This applies whether or not kid_hit is high in the same cycle.
  - kid_hit has priority over save_touch in the same cycle: no save update.
- DYING: a frame counter loads 0 on entry and increments on each frame_tick. When it reaches DEATH_FRAMES → DEAD_WAIT. Key edges are ignored. is_visiable holds.
- DEAD_WAIT: a key_start edge → RESPAWN. save is preserved.
- save, death_cnt and is_visiable change only as listed above.

## Timing

- All outputs are registered. An input sampled on edge N is reflected in the outputs after edge N (1-cycle latency).
- A frame_tick that coincides with the DYING entry edge is not counted.
- DYING → DEAD_WAIT occurs on the edge that samples the DEATH_FRAMES-th frame_tick.
- Reset values: state START, is_startpage=1, game_run=0, is_visiable=0, save=0, respawn=0, death_cnt=0, frame counter 0, key_q=1.
- Reset mid-operation returns to START immediately, asynchronously. A pending respawn pulse is dropped.

## Configuration

- GAME_PAUSE_EN defined:
  - A key_pause edge in PLAY → PAUSE. In PAUSE, game_run=0 and all registers hold; kid_hit, killer_trig and save_touch are ignored.
  - A key_pause edge in PAUSE → PLAY.
  - In PLAY, kid_hit on the same cycle as a key_pause edge wins (→ DYING).
- GAME_PAUSE_EN undefined: no PAUSE state; key_pause is ignored.

## Structure

- Shared package game_pkg holds:
  - the state enum typedef game_state_t;
  - typedef save_id_t (logic [1:0]);
  - the constant NUM_SAVES = 3.
- One sub-module, key_edge: a registered rising-edge detector with reset value 1, instantiated for key_start and key_pause.

## Test plan

- Reset with key_start held high, then release reset: state stays START, is_startpage=1. Release and press key_start → respawn pulses for 1 cycle with save=0, then game_run=1.
- In PLAY, save_touch with save_id=2, then with save_id=1 → save becomes 2 and stays 2.
- In PLAY, kid_hit, save_touch (save_id=3) and killer_trig asserted in the same cycle → DYING, save unchanged, is_visiable=1, death_cnt=1.
- DEATH_FRAMES=4: key_start edges during DYING are ignored. DEAD_WAIT is entered on the 4th frame_tick. The next key_start edge → respawn=1 with save preserved and is_visiable=0.
- 256 deaths with DCNT_W=8 → death_cnt saturates at 255.
- Reset_n pulsed low mid-DYING → is_startpage=1, save=0, death_cnt=0 immediately. With GAME_PAUSE_EN: pause/unpause in PLAY → game_run 0 then 1, and kid_hit is ignored while paused.
